// File: rtl/prelude_pkg.sv
// Shared types and constants for the prelude multi-cycle core.
// Contents: FSM state encoding, instruction class / ALU op / branch condition
// enums, the I/O register index and a branch-condition evaluation helper.
package prelude_pkg;

   typedef enum logic [2:0] {
      FETCH,
      EXEC,
      WAIT_IN,
      WAIT_OUT,
      HALT
   } state_e;

   typedef enum logic [1:0] {
      C_IMM = 2'b00,
      C_ALU = 2'b01,
      C_CPY = 2'b10,
      C_BR  = 2'b11
   } class_e;

   typedef enum logic [2:0] {
      OP_OR   = 3'd0,
      OP_NAND = 3'd1,
      OP_NOR  = 3'd2,
      OP_AND  = 3'd3,
      OP_ADD  = 3'd4,
      OP_SUB  = 3'd5,
      OP_SHL  = 3'd6,
      OP_ROR  = 3'd7
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_NEVER  = 3'd0,
      BR_EQ     = 3'd1,
      BR_LT     = 3'd2,
      BR_LE     = 3'd3,
      BR_ALWAYS = 3'd4,
      BR_NE     = 3'd5,
      BR_GE     = 3'd6,
      BR_GT     = 3'd7
   } cond_e;

   // Register index 7 is the I/O port, not storage.
   localparam logic [2:0] IO_REG = 3'd7;

   // Branch decision from the zero/sign flags of signed r3.
   function automatic logic br_taken(input cond_e c, input logic zero, input logic neg);
      logic t;
      t = 1'b0;
      case (c)
         BR_NEVER:  t = 1'b0;
         BR_EQ:     t = zero;
         BR_LT:     t = neg;
         BR_LE:     t = neg | zero;
         BR_ALWAYS: t = 1'b1;
         BR_NE:     t = ~zero;
         BR_GE:     t = ~neg;
         BR_GT:     t = ~neg & ~zero;
         default:   t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/prelude_if.sv
// Bus bundle between the prelude core and its environment.
// Signals: imem_addr/imem_data (synchronous instruction fetch),
// in_data/in_valid/in_ready (input handshake), out_data/out_valid/out_ready
// (output handshake). Modport master = core side, slave = environment side.
interface prelude_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 8
);
   localparam int unsigned IW = DW + 2;

   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_data;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output imem_addr, in_ready, out_data, out_valid,
      input  imem_data, in_data, in_valid, out_ready
   );

   modport slave (
      input  imem_addr, in_ready, out_data, out_valid,
      output imem_data, in_data, in_valid, out_ready
   );

endinterface

// File: rtl/prelude_alu_n.sv
// Combinational ALU for the prelude core.
// Ports: a (r1), b (r2), op (ALU op field) -> y_c (result), wr_c (r3 update enable).
// Build option: PRELUDE_SHIFT_EN adds SHL (op 6) and ROR (op 7); without it
// those ops deassert wr_c so r3 keeps its value and no shifter is built.
module prelude_alu_n
   import prelude_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  alu_op_e       op,
   output logic [DW-1:0] y_c,
   output logic          wr_c
);

`ifdef PRELUDE_SHIFT_EN
   localparam int unsigned SW = $clog2(DW);

   logic [SW-1:0] shamt;
   logic [31:0]   rot_amt;

   assign shamt   = b[SW-1:0];
   // Rotation is modulo DW so non-power-of-two widths still rotate correctly.
   assign rot_amt = 32'(shamt) % DW;
`endif

   // Result select; wr_c low means r3 is left untouched.
   always_comb begin
      y_c  = a;
      wr_c = 1'b1;
      case (op)
         OP_OR:   y_c = a | b;
         OP_NAND: y_c = ~(a & b);
         OP_NOR:  y_c = ~(a | b);
         OP_AND:  y_c = a & b;
         OP_ADD:  y_c = a + b;
         OP_SUB:  y_c = a - b;
`ifdef PRELUDE_SHIFT_EN
         OP_SHL:  y_c = a << shamt;
         OP_ROR:  y_c = (a >> rot_amt) | (a << (32'(DW) - rot_amt));
`else
         OP_SHL:  wr_c = 1'b0;
         OP_ROR:  wr_c = 1'b0;
`endif
         default: wr_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/prelude_core.sv
// prelude_core: multi-cycle Overture-style CPU with DW+2-bit instruction words.
// Ports: clk, rst_n (async active-low), bus (prelude_if.master: imem fetch,
// input and output valid/ready handshakes), halted (core stopped by HALT).
// Build option: PRELUDE_SHIFT_EN enables the SHL/ROR ALU ops (see prelude_alu_n).
module prelude_core
   import prelude_pkg::*;
#(
   parameter int unsigned DW       = 8,
   parameter int unsigned AW       = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   prelude_if.master   bus,
   output logic        halted
);

   localparam int unsigned IW = DW + 2;

   state_e        state;
   logic [AW-1:0] pc;
   logic [2:0]    ir_dst;
   logic [DW-1:0] rf [0:6];

   class_e        cls;
   logic [2:0]    src;
   logic [2:0]    dst;
   logic          taken;
   logic [DW-1:0] alu_y;
   logic          alu_wr;

   assign bus.imem_addr = pc;

   // Decode straight from imem_data: it is valid during EXEC.
   assign cls   = class_e'(bus.imem_data[IW-1 -: 2]);
   assign src   = bus.imem_data[5:3];
   assign dst   = bus.imem_data[2:0];
   assign taken = (cls == C_BR) &&
                  br_taken(cond_e'(bus.imem_data[2:0]), rf[3] == '0, rf[3][DW-1]);

   prelude_alu_n #(.DW(DW)) u_alu (
      .a    (rf[1]),
      .b    (rf[2]),
      .op   (alu_op_e'(bus.imem_data[2:0])),
      .y_c  (alu_y),
      .wr_c (alu_wr)
   );

   // FSM, pc, register file and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= FETCH;
         pc            <= AW'(RESET_PC);
         ir_dst        <= '0;
         for (int i = 0; i < 7; i++) rf[i] <= '0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         bus.in_ready  <= 1'b0;
         halted        <= 1'b0;
      end else begin
         case (state)
            FETCH: state <= EXEC;

            EXEC: begin
               // Only the destination field is needed after EXEC (WAIT_IN).
               ir_dst <= dst;
               pc     <= taken ? AW'(rf[0]) : pc + AW'(1);
               state  <= FETCH;
               case (cls)
                  C_IMM: rf[0] <= bus.imem_data[DW-1:0];
                  C_ALU: if (alu_wr) rf[3] <= alu_y;
                  C_CPY: begin
                     if (src == IO_REG && dst == IO_REG) begin
                        state  <= HALT;
                        halted <= 1'b1;
                     end else if (src == IO_REG) begin
                        state        <= WAIT_IN;
                        bus.in_ready <= 1'b1;
                     end else if (dst == IO_REG) begin
                        state         <= WAIT_OUT;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= rf[src];
                     end else begin
                        rf[dst] <= rf[src];
                     end
                  end
                  default: ;
               endcase
            end

            WAIT_IN: begin
               if (bus.in_valid) begin
                  rf[ir_dst]   <= bus.in_data;
                  bus.in_ready <= 1'b0;
                  state        <= FETCH;
               end
            end

            WAIT_OUT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= FETCH;
               end
            end

            HALT: state <= HALT;

            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_prelude_core.sv
// Directed self-checking bench for prelude_core (default DW=8, AW=8).
module tb_prelude_core;
   import prelude_pkg::*;

   localparam int unsigned DW       = 8;
   localparam int unsigned AW       = 8;
   localparam int unsigned IW       = DW + 2;
   localparam int unsigned RESET_PC = 0;

   logic clk = 1'b0;
   logic rst_n;
   logic halted;

   prelude_if #(.DW(DW), .AW(AW)) bus ();

   prelude_core #(.DW(DW), .AW(AW), .RESET_PC(RESET_PC)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .halted (halted)
   );

   always #5 clk = ~clk;

   logic [IW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] out_q [$];
   int            n_in;
   int            n_checks = 0;
   int            n_pass   = 0;

   // Synchronous instruction memory.
   always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

   // Transfer monitor.
   always @(posedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
      if (rst_n && bus.in_valid && bus.in_ready) n_in++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   function automatic logic [IW-1:0] i_imm(input int unsigned v);
      return {2'b00, DW'(v)};
   endfunction
   function automatic logic [IW-1:0] i_alu(input int unsigned op);
      return {2'b01, DW'(op)};
   endfunction
   function automatic logic [IW-1:0] i_cpy(input int unsigned s, input int unsigned d);
      return {2'b10, DW'(s * 8 + d)};
   endfunction
   function automatic logic [IW-1:0] i_br(input int unsigned c);
      return {2'b11, DW'(c)};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < (1 << AW); i++) mem[i] = i_cpy(7, 7);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic ordy);
      @(negedge clk);
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = ordy;
      repeat (2) @(negedge clk);
      out_q.delete();
      n_in  = 0;
      rst_n = 1'b1;
   endtask

   task automatic wait_out(input string tag, input int n, input int budget);
      int k = 0;
      while (out_q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      check(tag, 32'(out_q.size()), 32'(n));
   endtask

   task automatic check_q(input string tag, input int idx, input logic [DW-1:0] exp);
      logic [31:0] act;
      act = (idx < out_q.size()) ? 32'(out_q[idx]) : 32'hFFFF_FFFF;
      check(tag, act, 32'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] exp_alu [7];
      logic [DW-1:0] msb;
      int            hold;
      int            bad;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      // Reset state and a single output transfer.
      clear_mem();
      mem[0] = i_imm(8'hA5);
      mem[1] = i_cpy(0, 7);
      mem[2] = i_cpy(7, 7);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd0);
      check("rst_halted",    32'(halted),        32'd0);
      check("rst_pc",        32'(bus.imem_addr), RESET_PC);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      do_reset(1'b1);
      tick(4);
      check("out_valid_hi", 32'(bus.out_valid), 32'd1);
      check("out_data_a5",  32'(bus.out_data),  32'hA5);
      tick(1);
      check("out_valid_lo", 32'(bus.out_valid), 32'd0);
      check("pc_after_5",   32'(bus.imem_addr), 32'd2);
      check("out_count",    32'(out_q.size()),  32'd1);
      check_q("out_val", 0, DW'(8'hA5));

      // HALT: pc advances past the HALT word then freezes.
      tick(2);
      check("halted_set", 32'(halted), 32'd1);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.imem_addr !== AW'(3) || halted !== 1'b1) bad++;
         tick(1);
      end
      check("halt_freeze",   32'(bad),           32'd0);
      check("halt_addr",     32'(bus.imem_addr), 32'd3);
      check("halt_no_extra", 32'(out_q.size()),  32'd1);

      // ALU ops and branches.
      clear_mem();
      mem[0]  = i_imm(100);
      mem[1]  = i_cpy(0, 1);
      mem[2]  = i_cpy(0, 2);
      mem[3]  = i_alu(4);
      mem[4]  = i_cpy(3, 7);
      mem[5]  = i_imm(3);
      mem[6]  = i_cpy(0, 1);
      mem[7]  = i_imm(5);
      mem[8]  = i_cpy(0, 2);
      mem[9]  = i_alu(5);
      mem[10] = i_cpy(3, 7);
      mem[11] = i_imm(14);
      mem[12] = i_br(6);
      mem[13] = i_imm(20);
      mem[14] = i_br(2);
      mem[15] = i_imm(8'hEE);
      mem[16] = i_cpy(0, 7);
      mem[20] = i_imm(9);
      mem[21] = i_br(0);
      mem[22] = i_cpy(0, 7);
      mem[23] = i_alu(0);
      mem[24] = i_cpy(3, 7);
      mem[25] = i_alu(2);
      mem[26] = i_cpy(3, 7);
      mem[27] = i_alu(3);
      mem[28] = i_cpy(3, 7);
      mem[29] = i_alu(1);
      mem[30] = i_cpy(3, 7);
      exp_alu[0] = DW'(200);
      exp_alu[1] = DW'(-2);
      exp_alu[2] = DW'(9);
      exp_alu[3] = DW'(7);
      exp_alu[4] = ~DW'(7);
      exp_alu[5] = DW'(1);
      exp_alu[6] = ~DW'(1);
      do_reset(1'b1);
      wait_out("alu_count", 7, 400);
      check_q("alu_add",     0, exp_alu[0]);
      check_q("alu_sub",     1, exp_alu[1]);
      check_q("br_never",    2, exp_alu[2]);
      check_q("alu_or",      3, exp_alu[3]);
      check_q("alu_nor",     4, exp_alu[4]);
      check_q("alu_and",     5, exp_alu[5]);
      check_q("alu_nand",    6, exp_alu[6]);
      tick(6);
      check("alu_halted",  32'(halted),        32'd1);
      check("alu_halt_pc", 32'(bus.imem_addr), 32'd32);

      // Input handshake with a stalled producer.
      clear_mem();
      mem[0] = i_cpy(7, 2);
      mem[1] = i_cpy(2, 7);
      do_reset(1'b1);
      tick(2);
      hold = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.in_ready === 1'b1) hold++;
         tick(1);
      end
      check("in_ready_hold", 32'(hold), 32'd10);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(8'h3C);
      tick(1);
      bus.in_valid = 1'b0;
      check("in_ready_drop", 32'(bus.in_ready), 32'd0);
      wait_out("in_echo_count", 1, 50);
      check_q("in_echo", 0, DW'(8'h3C));
      check("in_xfers", 32'(n_in), 32'd1);

      // PC wrap on a non-branch at the top address.
      clear_mem();
      mem[0]            = i_imm((1 << AW) - 1);
      mem[1]            = i_br(4);
      mem[(1 << AW) - 1] = i_imm(8'h5A);
      do_reset(1'b1);
      tick(4);
      check("pc_top",  32'(bus.imem_addr), 32'((1 << AW) - 1));
      tick(2);
      check("pc_wrap", 32'(bus.imem_addr), 32'd0);

      // Output stall, then asynchronous reset mid-WAIT_OUT.
      clear_mem();
      mem[0] = i_imm(8'h42);
      mem[1] = i_cpy(0, 7);
      do_reset(1'b0);
      tick(7);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_data",  32'(bus.out_data),  32'h42);
      check("stall_pc",    32'(bus.imem_addr), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_pc",        32'(bus.imem_addr), RESET_PC);
      check("arst_no_xfer",   32'(out_q.size()),  32'd0);

      // Shift ops: active with PRELUDE_SHIFT_EN, NOPs otherwise.
      clear_mem();
      mem[0]  = i_imm(1);
      mem[1]  = i_cpy(0, 1);
      mem[2]  = i_cpy(0, 2);
      mem[3]  = i_imm(8'h33);
      mem[4]  = i_cpy(0, 3);
      mem[5]  = i_alu(6);
      mem[6]  = i_cpy(3, 7);
      mem[7]  = i_imm(8'h33);
      mem[8]  = i_cpy(0, 3);
      mem[9]  = i_alu(7);
      mem[10] = i_cpy(3, 7);
      msb     = '0;
      msb[DW-1] = 1'b1;
      do_reset(1'b1);
      wait_out("shift_count", 2, 200);
`ifdef PRELUDE_SHIFT_EN
      check_q("shl", 0, DW'(2));
      check_q("ror", 1, msb);
`else
      check_q("op6_nop", 0, DW'(8'h33));
      check_q("op7_nop", 1, DW'(8'h33));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
